// File: rtl/dpram64_arbiter.sv
// Two-requester round-robin arbiter and init sequencer for the dpram64 bench RAM.
// Optionally fills the array with CLEAR_WORD after reset, then grants one access per cycle.
module dpram64_arbiter #(
    parameter int unsigned SIZE       = 64,
    parameter bit          CLEAR_EN   = 1'b1,
    parameter logic [31:0] CLEAR_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        init_done,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int unsigned Words = SIZE / 4;
    localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            r_state, w_state_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              r_last, w_last_d;
    logic              r_rsp_pend, w_rsp_pend_d;
    logic              r_rsp_owner, w_rsp_owner_d;
    logic              r_rsp_is_read, w_rsp_is_read_d;

    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_sel_we;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;

    // Outputs are gated by rst_n so the bus is quiet while reset is held.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (rst_n && r_state == StRun) begin
            if (req0_valid && req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_last;
            end else if (req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b1;
            end
        end
    end

    assign w_sel_we    = w_grant_id ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant_id ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant_id ? req1_wdata : req0_wdata;

    assign req0_ready = w_grant_vld && !w_grant_id;
    assign req1_ready = w_grant_vld && w_grant_id;
    assign init_done  = (r_state == StRun);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_din   = '0;
        if (rst_n && r_state == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = 32'(r_cnt) << 2;
            mem_din   = CLEAR_WORD;
        end else if (w_grant_vld) begin
            if (w_sel_we) begin
                mem_we    = 1'b1;
                mem_waddr = w_sel_addr;
                mem_din   = w_sel_wdata;
            end else begin
                mem_raddr = w_sel_addr;
            end
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_last_d        = r_last;
        w_rsp_pend_d    = w_grant_vld;
        w_rsp_owner_d   = r_rsp_owner;
        w_rsp_is_read_d = r_rsp_is_read;
        if (r_state == StClear) begin
            if (r_cnt == CntW'(Words - 1)) begin
                w_state_d = StRun;
                w_cnt_d   = '0;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
        if (w_grant_vld) begin
            w_last_d        = w_grant_id;
            w_rsp_owner_d   = w_grant_id;
            w_rsp_is_read_d = ~w_sel_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CLEAR_EN ? StClear : StRun;
            r_cnt         <= '0;
            r_last        <= 1'b1;
            r_rsp_pend    <= 1'b0;
            r_rsp_owner   <= 1'b0;
            r_rsp_is_read <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_last        <= w_last_d;
            r_rsp_pend    <= w_rsp_pend_d;
            r_rsp_owner   <= w_rsp_owner_d;
            r_rsp_is_read <= w_rsp_is_read_d;
        end
    end

    assign rsp0_valid = r_rsp_pend && !r_rsp_owner;
    assign rsp1_valid = r_rsp_pend && r_rsp_owner;
    assign rsp0_rdata = (rsp0_valid && r_rsp_is_read) ? mem_dout : '0;
    assign rsp1_rdata = (rsp1_valid && r_rsp_is_read) ? mem_dout : '0;

endmodule
